// File: rtl/mem_arbiter_if.sv
// Bundle shared by the requesters, the arbiter and the memory controller.
// Handshake: a requester raises req[i] and holds it until done[i] pulses; gnt[i] marks its access in flight.
interface mem_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*AWIDTH-1:0] addr;
    logic [NUM_REQ*DWIDTH-1:0] wdata;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic                      err;
    logic [DWIDTH-1:0]         rdata;
    logic [AWIDTH-1:0]         mem_addr;
    logic [DWIDTH-1:0]         mem_wdata;
    logic                      mem_rw;
    logic                      mem_valid;
    logic [DWIDTH-1:0]         mem_rdata;

    // Environment side: requesters plus the memory controller's read data.
    modport master (
        output req, we, addr, wdata, mem_rdata,
        input  gnt, done, err, rdata, mem_addr, mem_wdata, mem_rw, mem_valid
    );

    modport slave (
        input  req, we, addr, wdata, mem_rdata,
        output gnt, done, err, rdata, mem_addr, mem_wdata, mem_rw, mem_valid
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that sequences requester accesses onto the single memory controller port.
// Misaligned requests are rejected without touching memory; all outputs are registered.
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic [1:0]        dbg_state
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                err_q, err_d;
    logic [DWIDTH-1:0]   rdata_q, rdata_d;
    logic [AWIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DWIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_rw_q, mem_rw_d;
    logic                mem_valid_q, mem_valid_d;

    logic                found;
    logic [IW-1:0]       sel_idx;
    logic [IW:0]         cand;
    logic [AWIDTH-1:0]   sel_addr;
    logic [DWIDTH-1:0]   sel_wdata;
    logic                sel_we;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
        if (v == IW'(NUM_REQ - 1)) return '0;
        return v + 1'b1;
    endfunction

    // First active request at or above the pointer, wrapping at NUM_REQ-1.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
            if (!found && bus.req[cand[IW-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IW-1:0];
            end
        end
    end

    assign sel_addr  = bus.addr[sel_idx*AWIDTH +: AWIDTH];
    assign sel_wdata = bus.wdata[sel_idx*DWIDTH +: DWIDTH];
    assign sel_we    = bus.we[sel_idx];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        done_d      = done_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rw_d    = mem_rw_q;
        mem_valid_d = mem_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (found) begin
                    idx_d = sel_idx;
                    if (sel_addr[1:0] != 2'b00) begin
                        // Rejected: no memory cycle, but the pointer still moves on.
                        done_d          = '0;
                        done_d[sel_idx] = 1'b1;
                        err_d           = 1'b1;
                        ptr_d           = wrap_inc(sel_idx);
                        state_d         = S_DONE;
                    end else begin
                        gnt_d          = '0;
                        gnt_d[sel_idx] = 1'b1;
                        mem_valid_d    = 1'b1;
                        mem_rw_d       = ~sel_we;
                        mem_addr_d     = sel_addr;
                        mem_wdata_d    = sel_wdata;
                        cnt_d          = CW'(MEM_LAT - 1);
                        state_d        = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_valid_d   = 1'b0;
                    gnt_d         = '0;
                    done_d        = '0;
                    done_d[idx_q] = 1'b1;
                    if (mem_rw_q) rdata_d = bus.mem_rdata;
                    ptr_d   = wrap_inc(idx_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = '0;
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b1;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rw    = mem_rw_q;
    assign bus.mem_valid = mem_valid_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single accesses plus hand-written
// sequences for contention, misaligned rejects, mid-access reset and mid-access input changes.
module tb_mem_arbiter;
    logic       clk;
    logic       reset;
    logic [1:0] dbg_state;
    int         checks;
    int         failures;

    mem_arbiter_if #(.NUM_REQ(2), .AWIDTH(32), .DWIDTH(32)) bus ();

    mem_arbiter #(.NUM_REQ(2), .AWIDTH(32), .DWIDTH(32), .MEM_LAT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Simple memory controller: word array, preloaded on reset.
    logic [31:0] mem_arr [64];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= '0;
            mem_arr[4]  <= 32'hDEADBEEF;
            mem_arr[17] <= 32'h44444444;
        end else if (bus.mem_valid && !bus.mem_rw) begin
            mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = bus.mem_valid ? mem_arr[bus.mem_addr[7:2]] : '0;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.we[i]            = w;
        bus.addr[i*32 +: 32]  = a;
        bus.wdata[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.req = '0;
        reset   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_vcnt;
    } vec_t;

    vec_t vecs [7];

    task automatic run_vec(input vec_t v);
        int   vcnt;
        bit   bus_ok;
        bit   seen;
        bit   gnt_clash;
        logic err_v;
        logic [31:0] rd_v;
        vcnt = 0; bus_ok = 1'b1; seen = 1'b0; gnt_clash = 1'b0; err_v = 1'b0; rd_v = '0;
        @(negedge clk);
        set_slot(v.idx, v.we, v.addr, v.wdata);
        bus.req[v.idx] = 1'b1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_valid) begin
                vcnt++;
                if (bus.mem_addr !== v.addr || bus.mem_rw !== ~v.we ||
                    (v.we && bus.mem_wdata !== v.wdata)) bus_ok = 1'b0;
            end
            if (bus.done[v.idx]) begin
                seen  = 1'b1;
                err_v = bus.err;
                rd_v  = bus.rdata;
                if (bus.gnt != '0) gnt_clash = 1'b1;
            end
        end
        bus.req[v.idx] = 1'b0;
        check({v.name, "_done"}, seen, 1'b1);
        check({v.name, "_valid_cycles"}, vcnt, v.exp_vcnt);
        check({v.name, "_mem_bus"}, bus_ok, 1'b1);
        check({v.name, "_err"}, err_v, v.exp_err);
        check({v.name, "_rdata"}, rd_v, v.exp_rdata);
        check({v.name, "_gnt_with_done"}, gnt_clash, 1'b0);
        @(negedge clk);
        check({v.name, "_done_clear"}, {bus.done, bus.err}, 3'b000);
    endtask

    // ---------------- test body ----------------
    initial begin
        int grants;
        int last_done;
        int first_gnt_cyc;
        logic [1:0] prev_gnt;
        logic [1:0] first_gnt;
        bit seen;
        bit vseen;
        bit stale;
        bit hold_ok;
        bit regrant;
        bit inv_bad;
        logic err_v;
        logic [31:0] rd_v;

        checks = 0; failures = 0;
        reset = 1'b0;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

        vecs[0] = '{"rd_deadbeef",   0, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 2};
        vecs[1] = '{"wr_20",         1, 1'b1, 32'h20, 32'h12345678, 1'b0, 32'hDEADBEEF, 2};
        vecs[2] = '{"rd_20",         1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h12345678, 2};
        vecs[3] = '{"rd_misaligned", 0, 1'b0, 32'h13, 32'h0,        1'b1, 32'h12345678, 0};
        vecs[4] = '{"wr_misaligned", 1, 1'b1, 32'h22, 32'hFFFF0000, 1'b1, 32'h12345678, 0};
        vecs[5] = '{"wr_30",         0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'h12345678, 2};
        vecs[6] = '{"rd_30",         0, 1'b0, 32'h30, 32'h0,        1'b0, 32'hA5A5A5A5, 2};

        // Reset values while reset is held low.
        repeat (3) @(negedge clk);
        check("rst_gnt_done_err", {bus.gnt, bus.done, bus.err}, 5'b0);
        check("rst_mem_valid_rw", {bus.mem_valid, bus.mem_rw}, 2'b01);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Contention: both requesters held high, strict alternation starting at 0.
        do_reset();
        set_slot(0, 1'b0, 32'h40, 32'h0);
        set_slot(1, 1'b0, 32'h44, 32'h0);
        bus.req = 2'b11;
        grants = 0; last_done = 0; prev_gnt = '0; inv_bad = 1'b0;
        for (int n = 0; n < 100 && grants < 8; n++) begin
            @(negedge clk);
            if ($countones(bus.gnt) > 1 || $countones(bus.done) > 1 ||
                (bus.gnt != '0 && bus.done != '0)) inv_bad = 1'b1;
            if (bus.gnt != '0 && prev_gnt == '0) begin
                check("rr_order", bus.gnt, (grants % 2 == 0) ? 2'b01 : 2'b10);
                if (grants > 0) check("rr_gap", n - last_done, 2);
                grants++;
            end
            if (bus.done != '0) last_done = n;
            prev_gnt = bus.gnt;
        end
        check("rr_grant_count", grants, 8);
        check("rr_onehot_invariants", inv_bad, 1'b0);
        bus.req = '0;

        // Misaligned reject under contention: pointer moves on to requester 1.
        do_reset();
        set_slot(0, 1'b0, 32'h13, 32'h0);
        set_slot(1, 1'b0, 32'h44, 32'h0);
        bus.req = 2'b11;
        seen = 1'b0; vseen = 1'b0; err_v = 1'b0; rd_v = '1;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_valid) vseen = 1'b1;
            if (bus.done[0]) begin
                seen    = 1'b1;
                err_v   = bus.err;
                rd_v    = bus.rdata;
                bus.req[0] = 1'b0;
            end
        end
        check("mis_done0", seen, 1'b1);
        check("mis_err", err_v, 1'b1);
        check("mis_no_mem_valid", vseen, 1'b0);
        check("mis_rdata_kept", rd_v, 32'h0);
        repeat (2) @(negedge clk);
        check("mis_next_gnt", bus.gnt, 2'b10);
        check("mis_next_addr", bus.mem_addr, 32'h44);
        bus.req = '0;

        // Reset one cycle into an access aborts it immediately.
        do_reset();
        set_slot(0, 1'b0, 32'h10, 32'h0);
        bus.req = 2'b01;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_valid) seen = 1'b1;
        end
        check("rst_mid_started", seen, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_drop", {bus.mem_valid, bus.gnt, bus.done}, 5'b0);
        bus.req = 2'b10;
        set_slot(1, 1'b0, 32'h10, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        first_gnt = '0; first_gnt_cyc = -1; stale = 1'b0; seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.gnt != '0 && first_gnt_cyc < 0) begin
                first_gnt     = bus.gnt;
                first_gnt_cyc = n;
            end
            if (bus.done[0]) stale = 1'b1;
            if (bus.done[1]) seen = 1'b1;
        end
        bus.req = '0;
        check("rst_mid_first_gnt", first_gnt, 2'b10);
        check("rst_mid_no_stale_done", stale, 1'b0);
        check("rst_mid_done1", seen, 1'b1);
        check("rst_mid_rdata", bus.rdata, 32'hDEADBEEF);

        // req dropped and address/we changed during the access.
        do_reset();
        set_slot(0, 1'b0, 32'h10, 32'h0);
        bus.req = 2'b01;
        vseen = 1'b0; hold_ok = 1'b1;
        for (int n = 0; n < 10 && !vseen; n++) begin
            @(negedge clk);
            if (bus.mem_valid) begin
                vseen = 1'b1;
                if (bus.mem_addr !== 32'h10 || bus.mem_rw !== 1'b1) hold_ok = 1'b0;
            end
        end
        bus.req[0] = 1'b0;
        set_slot(0, 1'b1, 32'h80, 32'hFFFFFFFF);
        seen = 1'b0; regrant = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (bus.mem_valid && (bus.mem_addr !== 32'h10 || bus.mem_rw !== 1'b1)) hold_ok = 1'b0;
            if (bus.done[0]) seen = 1'b1;
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.gnt != '0 || bus.mem_valid) regrant = 1'b1;
        end
        check("chg_access_started", vseen, 1'b1);
        check("chg_mem_bus_held", hold_ok, 1'b1);
        check("chg_done0", seen, 1'b1);
        check("chg_no_regrant", regrant, 1'b0);
        check("chg_rdata", bus.rdata, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
